icap_iprog_seq: RTL and testbench
=================================

ICAP_IPROG_SEQ -- requirements
Module: icap_iprog_seq

Interface
REQ-001 The block SHALL have parameter SPI_OPCODE, default 8'h0B, the SPI read opcode placed in GENERAL2[15:8].
REQ-002 The block SHALL have parameter BITSWAP, default 1: when 1, every ICAP data byte is bit-reversed (bit0<->bit7) before output.
REQ-003 The block SHALL have port clk_icap, input, 1 bit: the ICAP clock and the only clock of the block.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port spi_addr, input, 25 bits: SPI flash byte address of the target bitstream; only bits [23:0] are used.
REQ-006 The block SHALL have port REBOOT, input, 1 bit: reboot request, asynchronous to clk_icap.
REQ-007 The block SHALL have port icap_ce_n, output, 1 bit: active-low ICAP chip enable.
REQ-008 The block SHALL have port icap_we_n, output, 1 bit: active-low ICAP write enable.
REQ-009 The block SHALL have port icap_din, output, 16 bits: ICAP data word.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-012 REBOOT SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; the trigger is s2 & ~s3.
REQ-013 The FSM SHALL have states IDLE, SEND and FIN; IDLE->SEND on trigger, SEND->FIN after word 10, FIN->IDLE unconditionally after one cycle.
REQ-014 On the IDLE->SEND transition, spi_addr[23:0] SHALL be latched into addr_q; spi_addr changes during SEND/FIN SHALL have no effect.
REQ-015 In SEND, word index k (4-bit counter, 0..10) SHALL advance by one per clock with no stalls; the counter SHALL be cleared on entry to SEND.
REQ-016 The word sequence, before the BITSWAP transform, SHALL be:
- 0: FFFF
- 1: AA99
- 2: 5566
- 3: 3261
- 4: addr_q[15:0]
- 5: 3281
- 6: {SPI_OPCODE, addr_q[23:16]}
- 7: 30A1
- 8: 000E
- 9: 2000
- 10: 2000
REQ-017 icap_din, icap_ce_n and icap_we_n SHALL be registered; icap_ce_n=0 and icap_we_n=0 exactly during the 11 cycles in which words 0..10 are presented, and 1 otherwise.
REQ-018 Timing: with REBOOT first sampled high at edge E0, the FSM SHALL enter SEND at E2, word k SHALL be presented in the cycle following edge E(2+k), ce_n/we_n SHALL go high after E13, and done SHALL be high for the single cycle following E13.
REQ-019 busy SHALL be high from after E2 through the FIN cycle inclusive, and low in IDLE.
REQ-020 A trigger occurring while in SEND or FIN SHALL be ignored and not queued; a new sequence requires REBOOT to fall and rise again while in IDLE (s3 tracks s2 in all states).
REQ-021 REBOOT held high continuously SHALL produce exactly one sequence.
REQ-022 icap_din SHALL be 16'hFFFF whenever icap_ce_n=1 (shown for the BITSWAP=0 case; the value is invariant under the bit swap).

Reset
REQ-023 While rst=1, the block SHALL immediately and asynchronously force: state=IDLE, counter=0, s1/s2/s3=0, addr_q=0, icap_ce_n=1, icap_we_n=1, icap_din=FFFF, busy=0, done=0.
REQ-024 Assertion of rst mid-sequence SHALL abort the sequence with no further words emitted; after release, a sequence SHALL start only on a fresh trigger (REBOOT still high at release SHALL trigger, since s3=0).

Verification
REQ-025 Scenario, nominal (BITSWAP=0, spi_addr=25'h0080000, REBOOT pulse 0->1): the bench SHALL see words FFFF,AA99,5566,3261,0000,3281,0B08,30A1,000E,2000,2000 on consecutive cycles with ce_n=we_n=0, followed by a done pulse one cycle after the last word.
REQ-026 Scenario, bit swap (BITSWAP=1, same stimulus): the bench SHALL see word 1 = 5599, word 2 = AA66 and word 6 = D010.
REQ-027 Scenario, latency: REBOOT rises just before edge E0; the bench SHALL see the first ce_n low cycle after E2 and busy rise at the same point.
REQ-028 Scenario, re-trigger: REBOOT toggled 1->0->1 during word 5; the bench SHALL see exactly one sequence and one done pulse; a toggle after done SHALL start a second full sequence.
REQ-029 Scenario, reset mid-sequence: rst asserted during word 4; the bench SHALL see ce_n=1, busy=0 and icap_din=FFFF immediately; with REBOOT still high at release, a full sequence SHALL start 2 cycles after release.
REQ-030 Scenario, address capture: spi_addr changed from 0x0123456 to 0x0FFFFFF during word 2; the bench SHALL see word 4 = 3456 and word 6 = 0B12.

Source files
------------

// File: rtl/icap_iprog_seq_if.sv
// ICAP write port bundle driven by the IPROG reboot sequencer.
interface icap_iprog_seq_if;
    logic        icap_ce_n;
    logic        icap_we_n;
    logic [15:0] icap_din;

    modport master (
        output icap_ce_n,
        output icap_we_n,
        output icap_din
    );

    modport slave (
        input icap_ce_n,
        input icap_we_n,
        input icap_din
    );
endinterface

// File: rtl/icap_iprog_seq.sv
// Issues the 11-word IPROG command stream to ICAP on a REBOOT rising edge,
// pointing the configuration engine at an SPI flash bitstream address.
module icap_iprog_seq #(
    parameter logic [7:0] SPI_OPCODE = 8'h0B,
    parameter bit         BITSWAP    = 1'b1
) (
    input  logic                    clk_icap,
    input  logic                    rst,
    input  logic [24:0]             spi_addr,
    input  logic                    REBOOT,
    icap_iprog_seq_if.master        icap,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'd10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic        ce_n_q, ce_n_d;
    logic [15:0] din_q, din_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        trig;

    logic unused_addr_msb;
    assign unused_addr_msb = spi_addr[24];

    function automatic logic [15:0] word_at(
        input logic [3:0]  k,
        input logic [23:0] a
    );
        logic [15:0] w;
        case (k)
            4'd0:    w = 16'hFFFF;
            4'd1:    w = 16'hAA99;
            4'd2:    w = 16'h5566;
            4'd3:    w = 16'h3261;
            4'd4:    w = a[15:0];
            4'd5:    w = 16'h3281;
            4'd6:    w = {SPI_OPCODE, a[23:16]};
            4'd7:    w = 16'h30A1;
            4'd8:    w = 16'h000E;
            default: w = 16'h2000;
        endcase
        return w;
    endfunction

    // ICAP expects each byte MSB-first on D[0], hence the optional reversal.
    function automatic logic [15:0] xform(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (BITSWAP) begin
            for (int i = 0; i < 8; i++) begin
                r[i]     = w[7 - i];
                r[8 + i] = w[15 - i];
            end
        end
        return r;
    endfunction

    assign trig = s2_q & ~s3_q;

    always_comb begin
        s1_d    = REBOOT;
        s2_d    = s1_q;
        s3_d    = s2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ce_n_d  = 1'b1;
        din_d   = 16'hFFFF;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SEND;
                    cnt_d   = 4'd0;
                    addr_d  = spi_addr[23:0];
                    ce_n_d  = 1'b0;
                    din_d   = xform(word_at(4'd0, spi_addr[23:0]));
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    ce_n_d = 1'b0;
                    din_d  = xform(word_at(cnt_q + 4'd1, addr_q));
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_icap or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 24'd0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            ce_n_q  <= 1'b1;
            din_q   <= 16'hFFFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            ce_n_q  <= ce_n_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign icap.icap_ce_n = ce_n_q;
    assign icap.icap_we_n = ce_n_q;
    assign icap.icap_din  = din_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_icap_iprog_seq.sv
// Bench for icap_iprog_seq: directed scenarios plus random REBOOT/reset
// traffic, both bit-order variants checked every cycle against a model.
module tb_icap_iprog_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] spi_addr;
    logic        reboot;
    logic        busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    icap_iprog_seq_if if0 ();
    icap_iprog_seq_if if1 ();

    icap_iprog_seq #(.SPI_OPCODE(8'h0B), .BITSWAP(1'b0)) dut0 (
        .clk_icap(clk), .rst(rst), .spi_addr(spi_addr), .REBOOT(reboot),
        .icap(if0.master), .busy(busy0), .done(done0)
    );

    icap_iprog_seq #(.SPI_OPCODE(8'h0B), .BITSWAP(1'b1)) dut1 (
        .clk_icap(clk), .rst(rst), .spi_addr(spi_addr), .REBOOT(reboot),
        .icap(if1.master), .busy(busy1), .done(done1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: sequence position derived from REBOOT samples and the rules.
    function automatic logic [15:0] ref_word(input int k, input logic [23:0] a,
                                             input bit swap);
        logic [15:0] tbl [11];
        logic [15:0] w, r;
        tbl = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281,
                {8'h0B, a[23:16]}, 16'h30A1, 16'h000E, 16'h2000, 16'h2000};
        w = tbl[k];
        r = w;
        if (swap)
            for (int i = 0; i < 16; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
        return r;
    endfunction

    bit          hist [3];
    int          pos = -1;
    logic [23:0] m_addr = 24'd0;
    bit          trig;

    initial begin
        hist[0] = 1'b0;
        hist[1] = 1'b0;
        hist[2] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            hist[0] = 1'b0;
            hist[1] = 1'b0;
            hist[2] = 1'b0;
            pos = -1;
        end else begin
            trig = hist[1] && !hist[2];
            if (pos >= 0) begin
                pos++;
                if (pos > 11) pos = -1;
            end else if (trig) begin
                pos = 0;
                m_addr = spi_addr[23:0];
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = reboot;
        end
    end

    always @(negedge clk) begin
        logic        e_ce;
        logic [15:0] e_d0, e_d1;
        e_ce = !(pos >= 0 && pos <= 10);
        e_d0 = e_ce ? 16'hFFFF : ref_word(pos, m_addr, 1'b0);
        e_d1 = e_ce ? 16'hFFFF : ref_word(pos, m_addr, 1'b1);
        chk("ce_n0", 32'(if0.icap_ce_n), 32'(e_ce));
        chk("we_n0", 32'(if0.icap_we_n), 32'(e_ce));
        chk("din0",  32'(if0.icap_din),  32'(e_d0));
        chk("busy0", 32'(busy0), 32'(pos >= 0));
        chk("done0", 32'(done0), 32'(pos == 11));
        chk("ce_n1", 32'(if1.icap_ce_n), 32'(e_ce));
        chk("we_n1", 32'(if1.icap_we_n), 32'(e_ce));
        chk("din1",  32'(if1.icap_din),  32'(e_d1));
        chk("busy1", 32'(busy1), 32'(pos >= 0));
        chk("done1", 32'(done1), 32'(pos == 11));
    end

    logic [15:0] nom [11];
    logic [15:0] swp [11];
    int nd, nl;

    task automatic tally();
        @(negedge clk);
        if (done0) nd++;
        if (!if0.icap_ce_n) nl++;
    endtask

    initial begin
        nom = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000, 16'h3281,
                16'h0B08, 16'h30A1, 16'h000E, 16'h2000, 16'h2000};
        swp = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h4C86, 16'h0000, 16'h4C81,
                16'hD010, 16'h0C85, 16'h0070, 16'h0400, 16'h0400};
        rst = 1'b1;
        reboot = 1'b0;
        spi_addr = 25'd0;
        @(negedge clk);
        chk("rst_din", 32'(if0.icap_din), 32'hFFFF);
        chk("rst_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // nominal, latency, held-high
        #1 spi_addr = 25'h0080000;
        reboot = 1'b1;
        @(negedge clk);
        chk("lat_e0", 32'(if0.icap_ce_n), 32'd1);
        @(negedge clk);
        chk("lat_e1", 32'(if0.icap_ce_n), 32'd1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk($sformatf("nom_w%0d", k), 32'(if0.icap_din), 32'(nom[k]));
            chk($sformatf("swp_w%0d", k), 32'(if1.icap_din), 32'(swp[k]));
            chk("nom_ce", 32'(if0.icap_ce_n), 32'd0);
            if (k == 0) chk("lat_busy", 32'(busy0), 32'd1);
        end
        @(negedge clk);
        chk("nom_done", 32'(done0), 32'd1);
        chk("nom_ce_hi", 32'(if0.icap_ce_n), 32'd1);
        @(negedge clk);
        chk("nom_idle", 32'(busy0), 32'd0);
        nd = 0; nl = 0;
        repeat (20) tally();
        chk("held_dones", 32'(nd), 32'd0);

        // re-trigger during word 5 is ignored
        #1 reboot = 1'b0;
        repeat (3) @(negedge clk);
        #1 reboot = 1'b1;
        nd = 0; nl = 0;
        repeat (8) tally();
        chk("rt_w5", 32'(if0.icap_din), 32'h3281);
        #1 reboot = 1'b0;
        tally();
        #1 reboot = 1'b1;
        repeat (30) tally();
        chk("rt_dones", 32'(nd), 32'd1);
        chk("rt_words", 32'(nl), 32'd11);
        #1 reboot = 1'b0;
        repeat (3) @(negedge clk);
        #1 reboot = 1'b1;
        nd = 0; nl = 0;
        repeat (20) tally();
        chk("rt2_dones", 32'(nd), 32'd1);
        chk("rt2_words", 32'(nl), 32'd11);

        // address captured at start only
        #1 reboot = 1'b0;
        repeat (3) @(negedge clk);
        #1 spi_addr = 25'h0123456;
        reboot = 1'b1;
        repeat (5) @(negedge clk);
        #1 spi_addr = 25'h0FFFFFF;
        repeat (2) @(negedge clk);
        chk("cap_w4", 32'(if0.icap_din), 32'h3456);
        repeat (2) @(negedge clk);
        chk("cap_w6", 32'(if0.icap_din), 32'h0B12);
        repeat (8) @(negedge clk);

        // reset mid-sequence, REBOOT high through release
        #1 reboot = 1'b0;
        repeat (3) @(negedge clk);
        #1 spi_addr = 25'h0080000;
        reboot = 1'b1;
        repeat (7) @(negedge clk);
        chk("mr_w4", 32'(if0.icap_ce_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mr_ce", 32'(if0.icap_ce_n), 32'd1);
        chk("mr_busy", 32'(busy0), 32'd0);
        chk("mr_din0", 32'(if0.icap_din), 32'hFFFF);
        chk("mr_din1", 32'(if1.icap_din), 32'hFFFF);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_wait", 32'(if0.icap_ce_n), 32'd1);
        @(negedge clk);
        chk("mr_start", 32'(if0.icap_ce_n), 32'd0);
        chk("mr_w0", 32'(if0.icap_din), 32'hFFFF);
        repeat (12) @(negedge clk);

        // random traffic
        repeat (600) begin
            #1;
            if ($urandom_range(0, 9) == 0) reboot = ~reboot;
            spi_addr = 25'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        #1 rst = 1'b0;
        reboot = 1'b0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
